// File: rtl/encoder_8x3.sv
// Registered 8-to-3 priority encoder with valid/multi-hot status flags.
// Optional sticky multi-hot error flag enabled by defining ENCODER_8X3_STICKY_ERR_EN.
module encoder_8x3 #(
  parameter bit LOW_WINS = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d0,
  input  logic d1,
  input  logic d2,
  input  logic d3,
  input  logic d4,
  input  logic d5,
  input  logic d6,
  input  logic d7,
  output logic b0,
  output logic b1,
  output logic b2,
  output logic valid,
  output logic multi
`ifdef ENCODER_8X3_STICKY_ERR_EN
  ,
  output logic err_sticky
`endif
);

  logic [7:0] req;
  logic [2:0] idx_next;
  logic       valid_next;
  logic       multi_next;

  assign req = {d7, d6, d5, d4, d3, d2, d1, d0};

  // The last set bit visited wins, so scan order selects the priority direction.
  always_comb begin
    // NOTE: assign a default before any conditional logic so no path leaves idx_next unassigned (no latch).
    idx_next = 3'b000;
    if (LOW_WINS) begin
      for (int i = 7; i >= 0; i--) begin
        if (req[i]) idx_next = 3'(i);
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (req[i]) idx_next = 3'(i);
      end
    end
  end

  assign valid_next = |req;
  // Clearing the lowest set bit leaves something only when two or more bits were set.
  assign multi_next = (req & (req - 8'd1)) != 8'd0;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (rst) begin
      {b2, b1, b0} <= 3'b000;
      valid        <= 1'b0;
      multi        <= 1'b0;
    end else begin
      {b2, b1, b0} <= idx_next;
      valid        <= valid_next;
      multi        <= multi_next;
    end
  end

`ifdef ENCODER_8X3_STICKY_ERR_EN
  // Set on the same edge that registers multi=1; only reset clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_sticky <= 1'b0;
    end else if (multi_next) begin
      err_sticky <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_encoder_8x3.sv
// Self-checking bench for encoder_8x3: both priority directions side by side, scoreboard-driven.
// Define ENCODER_8X3_STICKY_ERR_EN to also check err_sticky.
module tb_encoder_8x3;

  typedef struct {
    string      tag;
    logic [4:0] hi;        // {code, valid, multi} for LOW_WINS=0
    logic [4:0] lo;        // {code, valid, multi} for LOW_WINS=1
    logic       sticky;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] d = 8'h00;

  logic hb0, hb1, hb2, hvalid, hmulti;
  logic lb0, lb1, lb2, lvalid, lmulti;
`ifdef ENCODER_8X3_STICKY_ERR_EN
  logic hsticky, lsticky;
`endif

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  logic sticky_model = 1'b0;

  always #5 clk = ~clk;

  encoder_8x3 #(.LOW_WINS(1'b0)) dut_hi (
    .clk(clk), .rst(rst),
    .d0(d[0]), .d1(d[1]), .d2(d[2]), .d3(d[3]),
    .d4(d[4]), .d5(d[5]), .d6(d[6]), .d7(d[7]),
    .b0(hb0), .b1(hb1), .b2(hb2), .valid(hvalid), .multi(hmulti)
`ifdef ENCODER_8X3_STICKY_ERR_EN
    , .err_sticky(hsticky)
`endif
  );

  encoder_8x3 #(.LOW_WINS(1'b1)) dut_lo (
    .clk(clk), .rst(rst),
    .d0(d[0]), .d1(d[1]), .d2(d[2]), .d3(d[3]),
    .d4(d[4]), .d5(d[5]), .d6(d[6]), .d7(d[7]),
    .b0(lb0), .b1(lb1), .b2(lb2), .valid(lvalid), .multi(lmulti)
`ifdef ENCODER_8X3_STICKY_ERR_EN
    , .err_sticky(lsticky)
`endif
  );

  // Reference encoder: explicit priority search, independent of the RTL's structure.
  function automatic logic [4:0] model(input logic [7:0] v, input bit low_wins);
    logic [2:0] code;
    code = 3'b000;
    if (low_wins) begin
      for (int i = 0; i < 8; i++) begin
        if (v[i]) begin code = 3'(i); break; end
      end
    end else begin
      for (int i = 7; i >= 0; i--) begin
        if (v[i]) begin code = 3'(i); break; end
      end
    end
    return {code, v != 8'h00, $countones(v) > 1};
  endfunction

  task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus, push its expectation, then compare after the capturing edge.
  task automatic step(input string tag, input logic r, input logic [7:0] v);
    exp_t e;
    @(negedge clk);
    rst = r;
    d   = v;
    if (r) begin
      e.hi = 5'b000_0_0;
      e.lo = 5'b000_0_0;
      sticky_model = 1'b0;
    end else begin
      e.hi = model(v, 1'b0);
      e.lo = model(v, 1'b1);
      if ($countones(v) > 1) sticky_model = 1'b1;
    end
    e.tag    = tag;
    e.sticky = sticky_model;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s: scoreboard empty observed=none expected=entry", tag);
    end else begin
      e = sb.pop_front();
      check({e.tag, "_hi"}, {hb2, hb1, hb0, hvalid, hmulti}, e.hi);
      check({e.tag, "_lo"}, {lb2, lb1, lb0, lvalid, lmulti}, e.lo);
`ifdef ENCODER_8X3_STICKY_ERR_EN
      check({e.tag, "_sticky_hi"}, {4'b0000, hsticky}, {4'b0000, e.sticky});
      check({e.tag, "_sticky_lo"}, {4'b0000, lsticky}, {4'b0000, e.sticky});
`endif
    end
  endtask

  initial begin
    // Reset held with d7 asserted, then released.
    step("rst0", 1'b1, 8'h80);
    step("rst1", 1'b1, 8'h80);
    step("rst_release", 1'b0, 8'h80);

    // One-hot walk with a mid-stream reset while d4 is high.
    step("walk_d0", 1'b0, 8'h01);
    step("walk_d1", 1'b0, 8'h02);
    step("walk_d2", 1'b0, 8'h04);
    step("walk_d3", 1'b0, 8'h08);
    step("walk_rst_d4", 1'b1, 8'h10);
    step("walk_d4", 1'b0, 8'h10);
    step("walk_d5", 1'b0, 8'h20);
    step("walk_d6", 1'b0, 8'h40);
    step("walk_d7", 1'b0, 8'h80);

    // All-zero input.
    step("zero", 1'b0, 8'h00);

    // Multi-hot patterns, each followed by one-hot inputs (sticky must persist).
    step("multi_d2_d5", 1'b0, 8'h24);
    step("after_multi_d3", 1'b0, 8'h08);
    step("multi_d0_d7", 1'b0, 8'h81);
    step("multi_all", 1'b0, 8'hFF);
    step("multi_d6_d7", 1'b0, 8'hC0);
    step("after_multi_d1", 1'b0, 8'h02);
    step("after_multi_zero", 1'b0, 8'h00);

    // Reset clears everything including the sticky flag; then normal operation.
    step("rst_clear", 1'b1, 8'h24);
    step("post_rst_d6", 1'b0, 8'h40);
    step("post_rst_d0", 1'b0, 8'h01);

    if (sb.size() != 0) begin
      total++;
      bad++;
      $error("FAIL scoreboard_drain: observed=%0d leftover expected=0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
